ozone_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the Ozone CPU. Owns the PC and drives the word

---
 rtl/ozone_fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_ozone_fetch_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ozone_fetch_stage.sv
// Ozone CPU instruction-fetch stage.
// Owns the PC, drives the word address of an asynchronous instruction ROM and
// registers the returned word into the IF/ID pipeline register. Supports
// delay-slot redirects, stall with a pending redirect, flush, and a sticky
// fault state for fetches outside the ROM window or from misaligned addresses.
module ozone_fetch_stage #(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] ROM_BASE = 32'hBFC00000,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_instr_i,
  output logic              if_valid_o,
  output logic [31:0]       if_instr_o,
  output logic [31:0]       if_pc_o,
  output logic [31:0]       if_pc4_o,
  output logic              fetch_fault_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Window size in bytes; one extra bit so the widest legal ADDR_W still fits.
  localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_W;

  state_t      state, state_next;

  logic [31:0] pc, pc_next;
  logic        pend_v, pend_v_next;
  logic [31:0] pend_pc, pend_pc_next;
  logic        if_valid, if_valid_next;
  logic [31:0] if_instr, if_instr_next;
  logic [31:0] if_pc, if_pc_next;
  logic [31:0] if_pc4, if_pc4_next;

  logic [31:0] offset;
  logic [31:0] pc_plus4;
  logic        fetch_ok;

  // An address below the base wraps to a huge offset, so a single unsigned
  // compare covers both window bounds.
  assign offset   = pc - ROM_BASE;
  assign pc_plus4 = pc + 32'd4;
  assign fetch_ok = ({1'b0, offset} < WIN_BYTES) && (pc[1:0] == 2'b00);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one boot cycle, enter FAULT on an unstalled bad fetch,
  // leave FAULT only through a flush carrying a redirect.
  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:  state_next = ST_RUN;
      ST_RUN: begin
        if (!flush_i && !stall_i && !fetch_ok) begin
          state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (flush_i && redirect_i) begin
          state_next = ST_RUN;
        end
      end
      default:  state_next = ST_BOOT;
    endcase
  end

  // Outputs decoded from state and PC.
  always_comb begin
    fetch_fault_o = (state == ST_FAULT);
    rom_addr_o    = offset[ADDR_W+1:2];
  end

  // PC, pending redirect and IF/ID register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      pend_v   <= 1'b0;
      pend_pc  <= 32'd0;
      if_valid <= 1'b0;
      if_instr <= 32'd0;
      if_pc    <= 32'd0;
      if_pc4   <= 32'd0;
    end else begin
      pc       <= pc_next;
      pend_v   <= pend_v_next;
      pend_pc  <= pend_pc_next;
      if_valid <= if_valid_next;
      if_instr <= if_instr_next;
      if_pc    <= if_pc_next;
      if_pc4   <= if_pc4_next;
    end
  end

  // Datapath next values; priority in RUN is flush, then stall, then advance.
  always_comb begin
    pc_next       = pc;
    pend_v_next   = pend_v;
    pend_pc_next  = pend_pc;
    if_valid_next = if_valid;
    if_instr_next = if_instr;
    if_pc_next    = if_pc;
    if_pc4_next   = if_pc4;
    case (state)
      ST_RUN: begin
        if (flush_i) begin
          if_valid_next = 1'b0;
          pend_v_next   = 1'b0;
          if (redirect_i) begin
            pc_next = redirect_pc_i;
          end
        end else if (stall_i) begin
          // Remember a redirect seen while stalled; the newest one wins.
          if (redirect_i) begin
            pend_pc_next = redirect_pc_i;
            pend_v_next  = 1'b1;
          end
        end else if (!fetch_ok) begin
          // Record the faulting PC; the ROM word is never marked valid.
          if_valid_next = 1'b0;
          if_pc_next    = pc;
          if_pc4_next   = pc_plus4;
          pend_v_next   = 1'b0;
        end else begin
          // The word fetched now is the delay slot of any redirect.
          if_valid_next = 1'b1;
          if_instr_next = rom_instr_i;
          if_pc_next    = pc;
          if_pc4_next   = pc_plus4;
          pend_v_next   = 1'b0;
          if (redirect_i) begin
            pc_next = redirect_pc_i;
          end else if (pend_v) begin
            pc_next = pend_pc;
          end else begin
            pc_next = pc_plus4;
          end
        end
      end
      ST_FAULT: begin
        if (flush_i && redirect_i) begin
          pc_next     = redirect_pc_i;
          pend_v_next = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  assign if_valid_o = if_valid;
  assign if_instr_o = if_instr;
  assign if_pc_o    = if_pc;
  assign if_pc4_o   = if_pc4;

endmodule

// File: tb/tb_ozone_fetch_stage.sv
// Directed testbench for ozone_fetch_stage with a small behavioural ROM.
module tb_ozone_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        flush_i;
  logic [4:0]  rom_addr_o;
  logic [31:0] rom_instr_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc4_o;
  logic        fetch_fault_o;

  int checks   = 0;
  int failures = 0;

  ozone_fetch_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .flush_i       (flush_i),
    .rom_addr_o    (rom_addr_o),
    .rom_instr_i   (rom_instr_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_pc4_o      (if_pc4_o),
    .fetch_fault_o (fetch_fault_o)
  );

  // Boot image: word 0 is 0x34010001, word n is 0x24000000 | n otherwise.
  always_comb begin
    if (rom_addr_o == 5'd0) rom_instr_i = 32'h34010001;
    else                    rom_instr_i = 32'h24000000 | {27'd0, rom_addr_o};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s got=%08h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic st, input logic rd, input logic [31:0] rpc, input logic fl);
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    flush_i       = fl;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    #2;
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_instr", if_instr_o, 32'd0);
    check("rst_pc", if_pc_o, 32'd0);
    check("rst_pc4", if_pc4_o, 32'd0);
    check("rst_fault", {31'd0, fetch_fault_o}, 32'd0);
    check("rst_addr", {27'd0, rom_addr_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: boot cycle, then first fetch
    step();
    check("boot_valid", {31'd0, if_valid_o}, 32'd0);
    check("boot_addr", {27'd0, rom_addr_o}, 32'd0);
    step();
    check("t1_valid", {31'd0, if_valid_o}, 32'd1);
    check("t1_instr", if_instr_o, 32'h34010001);
    check("t1_pc", if_pc_o, 32'hBFC00000);
    check("t1_pc4", if_pc4_o, 32'hBFC00004);
    check("t1_addr", {27'd0, rom_addr_o}, 32'd1);

    // 2: redirect while fetching word 8
    for (int i = 0; i < 7; i++) step();
    check("t2_addr8", {27'd0, rom_addr_o}, 32'd8);
    set_in(1'b0, 1'b1, 32'hBFC00038, 1'b0);
    step();
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    check("t2_slot_instr", if_instr_o, 32'h24000008);
    check("t2_slot_pc", if_pc_o, 32'hBFC00020);
    check("t2_addr", {27'd0, rom_addr_o}, 32'h0E);
    step();
    check("t2_tgt_pc", if_pc_o, 32'hBFC00038);
    check("t2_tgt_instr", if_instr_o, 32'h2400000E);

    // 3: stall three cycles with redirect in the first
    set_in(1'b1, 1'b1, 32'hBFC00064, 1'b0);
    step();
    set_in(1'b1, 1'b0, 32'd0, 1'b0);
    check("t3_hold0", if_pc_o, 32'hBFC00038);
    step();
    check("t3_hold1", if_pc_o, 32'hBFC00038);
    step();
    check("t3_hold2", if_pc_o, 32'hBFC00038);
    check("t3_hold_addr", {27'd0, rom_addr_o}, 32'h0F);
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    step();
    check("t3_slot_pc", if_pc_o, 32'hBFC0003C);
    check("t3_slot_instr", if_instr_o, 32'h2400000F);
    check("t3_addr", {27'd0, rom_addr_o}, 32'h19);

    // 4: redirect out of the window
    set_in(1'b0, 1'b1, 32'h00000038, 1'b0);
    step();
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    check("t4_slot_valid", {31'd0, if_valid_o}, 32'd1);
    check("t4_slot_pc", if_pc_o, 32'hBFC00064);
    step();
    check("t4_fault", {31'd0, fetch_fault_o}, 32'd1);
    check("t4_valid", {31'd0, if_valid_o}, 32'd0);
    check("t4_pc", if_pc_o, 32'h00000038);
    set_in(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    check("t4_stall_fault", {31'd0, fetch_fault_o}, 32'd1);
    set_in(1'b0, 1'b0, 32'd0, 1'b1);
    step();
    check("t4_flush_fault", {31'd0, fetch_fault_o}, 32'd1);
    check("t4_flush_pc", if_pc_o, 32'h00000038);
    set_in(1'b0, 1'b1, 32'hBFC00000, 1'b1);
    step();
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    check("t4_exit_fault", {31'd0, fetch_fault_o}, 32'd0);
    check("t4_exit_addr", {27'd0, rom_addr_o}, 32'd0);
    check("t4_exit_valid", {31'd0, if_valid_o}, 32'd0);

    // 5: sequential run to the end of the window
    for (int i = 0; i < 32; i++) step();
    check("t5_last_valid", {31'd0, if_valid_o}, 32'd1);
    check("t5_last_pc", if_pc_o, 32'hBFC0007C);
    check("t5_last_instr", if_instr_o, 32'h2400001F);
    step();
    check("t5_end_fault", {31'd0, fetch_fault_o}, 32'd1);
    check("t5_end_pc", if_pc_o, 32'hBFC00080);
    set_in(1'b0, 1'b1, 32'hBFC00000, 1'b1);
    step();
    set_in(1'b0, 1'b1, 32'hBFC00002, 1'b0);
    step();
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    check("t5_slot_pc", if_pc_o, 32'hBFC00000);
    step();
    check("t5_mis_fault", {31'd0, fetch_fault_o}, 32'd1);
    check("t5_mis_pc", if_pc_o, 32'hBFC00002);
    check("t5_mis_valid", {31'd0, if_valid_o}, 32'd0);

    // 6: reset while a redirect is pending
    set_in(1'b0, 1'b1, 32'hBFC00000, 1'b1);
    step();
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    step();
    set_in(1'b1, 1'b1, 32'hBFC00040, 1'b0);
    step();
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, if_valid_o}, 32'd0);
    check("t6_instr", if_instr_o, 32'd0);
    check("t6_pc", if_pc_o, 32'd0);
    check("t6_pc4", if_pc4_o, 32'd0);
    check("t6_fault", {31'd0, fetch_fault_o}, 32'd0);
    check("t6_addr", {27'd0, rom_addr_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("t6_boot_valid", {31'd0, if_valid_o}, 32'd0);
    step();
    check("t6_first_pc", if_pc_o, 32'hBFC00000);
    check("t6_first_instr", if_instr_o, 32'h34010001);
    check("t6_next_addr", {27'd0, rom_addr_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
